// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite round-robin arbiter.
// Build option: AHB_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
package ahb_arb_pkg;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   // Address-phase payload; this is all the hold buffer has to keep.
   typedef struct packed {
      htrans_e           htrans;
      logic [2:0]        hsize;
      logic              hwrite;
      logic [ADDR_W-1:0] haddr;
   } ahb_req_t;

endpackage

// File: rtl/ahb_rr_arbiter2_if.sv
// AHB-Lite link. The slave modport is the arbiter facing a master;
// the master modport is the arbiter facing the downstream slave.
interface ahb_rr_arbiter2_if
   import ahb_arb_pkg::*;
#(
   parameter int ADDR_W = ahb_arb_pkg::ADDR_W,
   parameter int DATA_W = ahb_arb_pkg::DATA_W
);
   htrans_e           htrans;
   logic [2:0]        hsize;
   logic              hwrite;
   logic [ADDR_W-1:0] haddr;
   logic [DATA_W-1:0] hwdata;
   logic              hready;
   logic              hreadyout;
   logic              hresp;
   logic [DATA_W-1:0] hrdata;

   modport slave (
      input  htrans, hsize, hwrite, haddr, hwdata,
      output hready, hresp, hrdata
   );

   modport master (
      output htrans, hsize, hwrite, haddr, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_arb_hold_buf.sv
// One-entry address-phase hold buffer for a single master port.
// Captures an accepted address phase that cannot go straight to the slave.
module ahb_arb_hold_buf
   import ahb_arb_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  ahb_req_t live,
   input  logic     in_hready,
   input  logic     direct,
   input  logic     clear,
   output logic     pend,
   output ahb_req_t hold
);
   logic capture;

   // The master saw hready=1, so the address is gone from its bus unless
   // it is forwarded on this very edge.
   assign capture = in_hready & live.htrans[1] & ~(direct & ~pend);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pend <= 1'b0;
      end else if (capture) begin
         pend <= 1'b1;
      end else if (clear) begin
         pend <= 1'b0;
      end
   end

   // NOTE: the payload register has no reset; pend qualifies it, and leaving
   // it unreset keeps the datapath free of reset fan-out.
   always_ff @(posedge clock) begin
      if (capture) begin
         hold <= live;
      end
   end

endmodule

// File: rtl/ahb_rr_arbiter2.sv
// Two-master AHB-Lite arbiter with per-port address hold buffers, round-robin per transfer.
// Build option: define AHB_ARB_FIXED_PRIO_EN for fixed priority with port 0 highest.
module ahb_rr_arbiter2
   import ahb_arb_pkg::*;
#(
   parameter int ADDR_W = ahb_arb_pkg::ADDR_W,
   parameter int DATA_W = ahb_arb_pkg::DATA_W
) (
   input  logic               clock,
   input  logic               reset_n,
   ahb_rr_arbiter2_if.slave   auto_in_0,
   ahb_rr_arbiter2_if.slave   auto_in_1,
   ahb_rr_arbiter2_if.master  auto_out
);
   logic       grant;
   logic       own_v;
   logic       own_id;
   logic       last_src;
   logic [1:0] pend;
   logic [1:0] req;
   logic [1:0] in_hready;
   logic [1:0] in_hresp;
   logic       fwd;
   ahb_req_t   live [2];
   ahb_req_t   hold [2];
   ahb_req_t   src;
   htrans_e    out_htrans;

   assign live[0] = '{htrans: auto_in_0.htrans, hsize: auto_in_0.hsize,
                      hwrite: auto_in_0.hwrite, haddr: auto_in_0.haddr};
   assign live[1] = '{htrans: auto_in_1.htrans, hsize: auto_in_1.hsize,
                      hwrite: auto_in_1.hwrite, haddr: auto_in_1.haddr};

   for (genvar i = 0; i < 2; i++) begin : g_port
      ahb_arb_hold_buf u_hold (
         .clock     (clock),
         .reset_n   (reset_n),
         .live      (live[i]),
         .in_hready (in_hready[i]),
         .direct    ((grant == 1'(i)) & auto_out.hreadyout),
         .clear     (fwd & (grant == 1'(i))),
         .pend      (pend[i]),
         .hold      (hold[i])
      );
      assign req[i] = pend[i] | live[i].htrans[1];
   end

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      src        = pend[grant] ? hold[grant] : live[grant];
      out_htrans = HTRANS_IDLE;
      if (reset_n && src.htrans[1]) begin
         // A buffered or interleaved beat no longer continues the slave's last burst.
         if (src.htrans == HTRANS_SEQ && (pend[grant] || last_src != grant)) begin
            out_htrans = HTRANS_NONSEQ;
         end else begin
            out_htrans = src.htrans;
         end
      end
   end

   assign fwd = auto_out.hreadyout & (out_htrans != HTRANS_IDLE);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         in_hready[i] = 1'b1;
         in_hresp[i]  = 1'b0;
         if (reset_n && own_v && own_id == 1'(i)) begin
            in_hready[i] = auto_out.hreadyout;
            in_hresp[i]  = auto_out.hresp;
         end else if (reset_n && pend[i]) begin
            in_hready[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         grant    <= 1'b0;
         own_v    <= 1'b0;
         own_id   <= 1'b0;
         last_src <= 1'b0;
      end else if (auto_out.hreadyout) begin
         if (fwd) begin
            own_v    <= 1'b1;
            own_id   <= grant;
            last_src <= grant;
         end else begin
            own_v    <= 1'b0;
         end
`ifdef AHB_ARB_FIXED_PRIO_EN
         if (req[0]) begin
            grant <= 1'b0;
         end else if (req[1]) begin
            grant <= 1'b1;
         end
`else
         if (req[~grant]) begin
            grant <= ~grant;
         end
`endif
      end
   end

   assign auto_out.htrans = out_htrans;
   assign auto_out.hsize  = src.hsize;
   assign auto_out.hwrite = src.hwrite;
   assign auto_out.haddr  = src.haddr;
   assign auto_out.hwdata = own_id ? auto_in_1.hwdata : auto_in_0.hwdata;
   assign auto_out.hready = auto_out.hreadyout;

   assign auto_in_0.hready = in_hready[0];
   assign auto_in_1.hready = in_hready[1];
   assign auto_in_0.hresp  = in_hresp[0];
   assign auto_in_1.hresp  = in_hresp[1];
   assign auto_in_0.hrdata = auto_out.hrdata;
   assign auto_in_1.hrdata = auto_out.hrdata;

endmodule

// File: tb/tb_ahb_rr_arbiter2.sv
// Directed self-checking bench for ahb_rr_arbiter2.
// Expected values are hand-derived cycle by cycle from the arbitration rules.
module tb_ahb_rr_arbiter2;
   import ahb_arb_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   ahb_rr_arbiter2_if m0 ();
   ahb_rr_arbiter2_if m1 ();
   ahb_rr_arbiter2_if s0 ();

   ahb_rr_arbiter2 dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .auto_in_0 (m0.slave),
      .auto_in_1 (m1.slave),
      .auto_out  (s0.master)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven, then checked after settle().
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input int p, input htrans_e t, input logic [29:0] a,
                        input logic w, input logic [31:0] d);
      if (p == 0) begin
         m0.htrans = t; m0.haddr = a; m0.hwrite = w; m0.hsize = 3'd2; m0.hwdata = d;
      end else begin
         m1.htrans = t; m1.haddr = a; m1.hwrite = w; m1.hsize = 3'd2; m1.hwdata = d;
      end
   endtask

   task automatic idle_all();
      drive(0, HTRANS_IDLE, '0, 1'b0, '0);
      drive(1, HTRANS_IDLE, '0, 1'b0, '0);
   endtask

   initial begin
      idle_all();
      m0.hreadyout = 1'b1; m1.hreadyout = 1'b1;
      s0.hreadyout = 1'b1; s0.hresp = 1'b0; s0.hrdata = '0;
      step(); step();
      reset_n = 1'b1;
      settle();
      check("rst_in0_hready", 32'(m0.hready), 32'd1);
      check("rst_in1_hready", 32'(m1.hready), 32'd1);
      check("rst_out_htrans", 32'(s0.htrans), 32'(HTRANS_IDLE));
      check("rst_in0_hresp",  32'(m0.hresp), 32'd0);

      // Granted idle port forwards the same cycle; write data follows one cycle later.
      drive(0, HTRANS_NONSEQ, 30'h100, 1'b1, 32'h0);
      settle();
      check("p0_wr_htrans", 32'(s0.htrans), 32'(HTRANS_NONSEQ));
      check("p0_wr_haddr",  32'(s0.haddr), 32'h100);
      check("p0_wr_hwrite", 32'(s0.hwrite), 32'd1);
      step();
      drive(0, HTRANS_IDLE, '0, 1'b0, 32'hA5A5_A5A5);
      settle();
      check("p0_wr_hwdata", s0.hwdata, 32'hA5A5_A5A5);
      check("p0_wr_dphase_hready", 32'(m0.hready), 32'd1);
      check("p0_wr_out_idle", 32'(s0.htrans), 32'(HTRANS_IDLE));
      step();

      // Both request together: P0 goes first, P1 waits in its hold buffer.
      drive(0, HTRANS_NONSEQ, 30'h200, 1'b0, '0);
      drive(1, HTRANS_NONSEQ, 30'h300, 1'b0, '0);
      settle();
      check("both_first_addr", 32'(s0.haddr), 32'h200);
      check("both_in1_hready_pre", 32'(m1.hready), 32'd1);
      step();
      idle_all();
      s0.hrdata = 32'h1111_1111;
      settle();
      check("both_second_addr",   32'(s0.haddr), 32'h300);
      check("both_second_htrans", 32'(s0.htrans), 32'(HTRANS_NONSEQ));
      check("both_in1_hready_wait", 32'(m1.hready), 32'd0);
      check("both_in0_hready",    32'(m0.hready), 32'd1);
      check("both_in0_hrdata",    m0.hrdata, 32'h1111_1111);
      step();
      settle();
      check("both_in1_dphase_hready", 32'(m1.hready), 32'd1);
      check("both_out_idle", 32'(s0.htrans), 32'(HTRANS_IDLE));
      step();

      // P0 INCR burst interleaved with P1 (grant currently 1).
      drive(0, HTRANS_NONSEQ, 30'h400, 1'b0, '0);
      drive(1, HTRANS_NONSEQ, 30'h500, 1'b0, '0);
      settle();
      check("incr_p1_first", 32'(s0.haddr), 32'h500);
      step();
      drive(0, HTRANS_SEQ, 30'h404, 1'b0, '0);
      drive(1, HTRANS_NONSEQ, 30'h504, 1'b0, '0);
      settle();
      check("incr_beat1_addr", 32'(s0.haddr), 32'h400);
      check("incr_beat1_htrans", 32'(s0.htrans), 32'(HTRANS_NONSEQ));
      check("incr_in0_hready_held", 32'(m0.hready), 32'd0);
      step();
      drive(1, HTRANS_IDLE, '0, 1'b0, '0);
      settle();
      check("incr_p1_second", 32'(s0.haddr), 32'h504);
      check("incr_in1_hready_wait", 32'(m1.hready), 32'd0);
      step();
      drive(0, HTRANS_SEQ, 30'h408, 1'b0, '0);
      settle();
      check("incr_beat2_addr", 32'(s0.haddr), 32'h404);
      check("incr_beat2_rewrite", 32'(s0.htrans), 32'(HTRANS_NONSEQ));
      step();
      settle();
      check("incr_beat3_seq", 32'(s0.htrans), 32'(HTRANS_SEQ));
      check("incr_beat3_addr", 32'(s0.haddr), 32'h408);
      step();
      drive(0, HTRANS_BUSY, 30'h40C, 1'b0, '0);
      settle();
      check("incr_busy_hidden", 32'(s0.htrans), 32'(HTRANS_IDLE));
      step();
      drive(0, HTRANS_SEQ, 30'h40C, 1'b0, '0);
      settle();
      check("incr_beat4_seq", 32'(s0.htrans), 32'(HTRANS_SEQ));
      step();
      idle_all();
      step();

      // Two-cycle ERROR on a P1 read reaches only P1.
      drive(1, HTRANS_NONSEQ, 30'h600, 1'b0, '0);
      settle();
      check("err_out_idle_first", 32'(s0.htrans), 32'(HTRANS_IDLE));
      step();
      idle_all();
      settle();
      check("err_p1_addr", 32'(s0.haddr), 32'h600);
      check("err_in1_hready_wait", 32'(m1.hready), 32'd0);
      step();
      s0.hreadyout = 1'b0; s0.hresp = 1'b1;
      settle();
      check("err1_in1_hready", 32'(m1.hready), 32'd0);
      check("err1_in1_hresp",  32'(m1.hresp), 32'd1);
      check("err1_in0_hresp",  32'(m0.hresp), 32'd0);
      step();
      s0.hreadyout = 1'b1;
      settle();
      check("err2_in1_hready", 32'(m1.hready), 32'd1);
      check("err2_in1_hresp",  32'(m1.hresp), 32'd1);
      check("err2_in0_hresp",  32'(m0.hresp), 32'd0);
      step();
      s0.hresp = 1'b0;

      // Reset while both ports hold buffered transfers and the slave stalls.
      s0.hreadyout = 1'b0;
      drive(0, HTRANS_NONSEQ, 30'h800, 1'b0, '0);
      drive(1, HTRANS_NONSEQ, 30'h700, 1'b0, '0);
      step();
      settle();
      check("rstp_in1_hready_pend", 32'(m1.hready), 32'd0);
      check("rstp_in0_hready_pend", 32'(m0.hready), 32'd0);
      reset_n = 1'b0;
      settle();
      check("rstp_during_htrans", 32'(s0.htrans), 32'(HTRANS_IDLE));
      check("rstp_during_in1_hready", 32'(m1.hready), 32'd1);
      step();
      reset_n = 1'b1;
      idle_all();
      settle();
      check("rstp_after_htrans", 32'(s0.htrans), 32'(HTRANS_IDLE));
      check("rstp_after_in0_hready", 32'(m0.hready), 32'd1);
      check("rstp_after_in1_hready", 32'(m1.hready), 32'd1);

      // P0 keeps requesting while P1 waits: arbitration policy decides who is next.
      s0.hreadyout = 1'b1;
      drive(0, HTRANS_NONSEQ, 30'h900, 1'b0, '0);
      drive(1, HTRANS_NONSEQ, 30'hA00, 1'b0, '0);
      settle();
      check("pol_first", 32'(s0.haddr), 32'h900);
      step();
      drive(0, HTRANS_NONSEQ, 30'h904, 1'b0, '0);
      drive(1, HTRANS_IDLE, '0, 1'b0, '0);
      settle();
`ifdef AHB_ARB_FIXED_PRIO_EN
      check("pol_second_p0", 32'(s0.haddr), 32'h904);
      check("pol_in1_starved", 32'(m1.hready), 32'd0);
`else
      check("pol_second_p1", 32'(s0.haddr), 32'hA00);
`endif
      step();
      drive(0, HTRANS_IDLE, '0, 1'b0, '0);
      settle();
`ifdef AHB_ARB_FIXED_PRIO_EN
      check("pol_third_idle", 32'(s0.htrans), 32'(HTRANS_IDLE));
      step();
      settle();
      check("pol_p1_served", 32'(s0.haddr), 32'hA00);
      check("pol_p1_htrans", 32'(s0.htrans), 32'(HTRANS_NONSEQ));
`else
      check("pol_third_p0", 32'(s0.haddr), 32'h904);
      check("pol_third_htrans", 32'(s0.htrans), 32'(HTRANS_NONSEQ));
`endif
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
